// File: rtl/nv_pwr_iso_seq_if.sv
// nv_pwr_iso_seq_if: request/ack inputs and isolation/switch/reset outputs of the power sequencer
interface nv_pwr_iso_seq_if;
  logic       pwr_down_req;
  logic       pwr_sw_ack;
  logic       err_clr;
  logic       iso_en_n;
  logic       pwr_sw_en;
  logic       domain_rstn;
  logic [1:0] pwr_state;
  logic       pwr_busy;
  logic       pwr_timeout_err;
  modport master (
    output pwr_down_req, pwr_sw_ack, err_clr,
    input  iso_en_n, pwr_sw_en, domain_rstn, pwr_state, pwr_busy, pwr_timeout_err
  );
  modport slave (
    input  pwr_down_req, pwr_sw_ack, err_clr,
    output iso_en_n, pwr_sw_en, domain_rstn, pwr_state, pwr_busy, pwr_timeout_err
  );
endinterface

// File: rtl/nv_pwr_iso_seq.sv
// nv_pwr_iso_seq: orders isolation, domain reset and power-switch enable for one switchable domain
module nv_pwr_iso_seq #(
  parameter int ISO_SETUP_CYC = 4,
  parameter int ACK_TIMEOUT   = 255,
  parameter int CNT_W         = 8
) (
  input logic            nvdla_core_clk,
  input logic            nvdla_core_rstn,
  nv_pwr_iso_seq_if.slave pwr
);
  typedef enum logic [2:0] {PU_ACK, PU_RST, PU_ISO, ON, PD_ISO, PD_RST, PD_ACK, OFF} state_t;
  localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] ACK_LIM  = CNT_W'(ACK_TIMEOUT);
  state_t           state, state_nx;
  logic [CNT_W-1:0] timer, timer_nx;
  logic             ack_m, ack_s;
  logic             wait_st, iso_nx, rstn_nx, sw_nx, err_nx;
  logic [1:0]       st_nx;
  always_comb begin
    state_nx = state;
    case (state)
      PU_ACK: if (ack_s) state_nx = PU_RST;
      PU_RST: if (timer == ISO_LAST) state_nx = PU_ISO;
      PU_ISO: if (timer == ISO_LAST) state_nx = ON;
      ON:     if (pwr.pwr_down_req) state_nx = PD_ISO;
      PD_ISO: if (timer == ISO_LAST) state_nx = PD_RST;
      PD_RST: if (timer == ISO_LAST) state_nx = PD_ACK;
      PD_ACK: if (!ack_s) state_nx = OFF;
      OFF:    if (!pwr.pwr_down_req) state_nx = PU_ACK;
    endcase
  end
  assign wait_st  = state inside {PU_ACK, PD_ACK};
  // ack wait saturates at the limit so the timeout condition stays asserted while waiting
  assign timer_nx = (state_nx != state || state inside {ON, OFF}) ? '0 :
                    (wait_st && timer == ACK_LIM) ? timer : timer + 1'b1;
  assign err_nx   = (wait_st && state_nx == state && timer_nx == ACK_LIM) ||
                    (pwr.pwr_timeout_err && !pwr.err_clr);
  // outputs are decoded from the next state and registered, so they track state exactly
  assign iso_nx   = state_nx == ON;
  assign rstn_nx  = state_nx inside {PU_ISO, ON, PD_ISO};
  assign sw_nx    = !(state_nx inside {PD_ACK, OFF});
  assign st_nx    = state_nx == OFF ? 2'b00 :
                    state_nx == ON ? 2'b10 :
                    state_nx inside {PU_ACK, PU_RST, PU_ISO} ? 2'b01 : 2'b11;
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state               <= PU_ACK;
      timer               <= '0;
      ack_m               <= 1'b0;
      ack_s               <= 1'b0;
      pwr.iso_en_n        <= 1'b0;
      pwr.domain_rstn     <= 1'b0;
      pwr.pwr_sw_en       <= 1'b1;
      pwr.pwr_state       <= 2'b01;
      pwr.pwr_busy        <= 1'b1;
      pwr.pwr_timeout_err <= 1'b0;
    end else begin
      state               <= state_nx;
      timer               <= timer_nx;
      ack_m               <= pwr.pwr_sw_ack;
      ack_s               <= ack_m;
      pwr.iso_en_n        <= iso_nx;
      pwr.domain_rstn     <= rstn_nx;
      pwr.pwr_sw_en       <= sw_nx;
      pwr.pwr_state       <= st_nx;
      pwr.pwr_busy        <= st_nx[0];
      pwr.pwr_timeout_err <= err_nx;
    end
  end
endmodule
